// File: rtl/ula_src_ctrl.sv
// Multicycle control sequencer: steps one state per clock and drives ALU operand
// selects, ALU op, PC/IR write enables and memory strobes as registered Moore outputs.
module ula_src_ctrl #(
    parameter int unsigned MEM_WAIT = 2,
    parameter int unsigned CNT_W    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       overflow,
    output logic       ULAa,
    output logic [2:0] ULAb,
    output logic [2:0] ULAop,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       exc,
    output logic [3:0] state
);

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_J    = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] SRC_B     = 3'b000;
    localparam logic [2:0] SRC_EXT   = 3'b001;
    localparam logic [2:0] SRC_FOUR  = 3'b010;
    localparam logic [2:0] SRC_EXTSH = 3'b100;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_WAIT - 1);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_EXEC_I = 4'd3,
        S_ADDR   = 4'd4,
        S_MEM_RD = 4'd5,
        S_MEM_WR = 4'd6,
        S_BRANCH = 4'd7,
        S_JUMP   = 4'd8,
        S_WB     = 4'd9,
        S_TRAP   = 4'd10
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [5:0]       r_opcode;
    logic [5:0]       r_funct;
    logic [5:0]       w_op;
    logic [5:0]       w_fn;
    logic             w_last;
    logic             w_fn_ok;
    logic             w_fn_arith;

    logic             w_ulaa;
    logic [2:0]       w_ulab;
    logic [2:0]       w_ulaop;
    logic             w_pcw;
    logic             w_irw;
    logic             w_mr;
    logic             w_mw;
    logic             w_rw;
    logic             w_exc;

    // Live inputs while decoding; the captured copy for the rest of the instruction.
    assign w_op       = (r_state == S_DECODE) ? opcode : r_opcode;
    assign w_fn       = (r_state == S_DECODE) ? funct  : r_funct;
    assign w_last     = (r_cnt == CNT_LAST);
    assign w_fn_arith = (w_fn == FN_ADD) || (w_fn == FN_SUB);
    assign w_fn_ok    = w_fn_arith || (w_fn == FN_AND) || (w_fn == FN_OR) || (w_fn == FN_SLT);
    assign state      = 4'(r_state);

    // Next state and wait counter; the counter is cleared whenever a wait state is left.
    always_comb begin
        w_next     = r_state;
        w_cnt_next = '0;
        case (r_state)
            S_FETCH: begin
                if (w_last) w_next = S_DECODE;
                else        w_cnt_next = r_cnt + CNT_W'(1);
            end
            S_DECODE: begin
                case (opcode)
                    OP_R:          w_next = S_EXEC_R;
                    OP_ADDI:       w_next = S_EXEC_I;
                    OP_LW, OP_SW:  w_next = S_ADDR;
                    OP_BEQ, OP_BNE: w_next = S_BRANCH;
                    OP_J:          w_next = S_JUMP;
                    default:       w_next = S_TRAP;
                endcase
            end
            S_EXEC_R: w_next = (!w_fn_ok || (overflow && w_fn_arith)) ? S_TRAP : S_WB;
            S_EXEC_I: w_next = overflow ? S_TRAP : S_WB;
            S_ADDR:   w_next = (w_op == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: begin
                if (w_last) w_next = S_WB;
                else        w_cnt_next = r_cnt + CNT_W'(1);
            end
            S_MEM_WR: begin
                if (w_last) w_next = S_FETCH;
                else        w_cnt_next = r_cnt + CNT_W'(1);
            end
            default:  w_next = S_FETCH;
        endcase
    end

    // Output decode of the upcoming state, so the registered outputs line up with r_state.
    always_comb begin
        w_ulaa  = 1'b0;
        w_ulab  = SRC_B;
        w_ulaop = ALU_ADD;
        w_pcw   = 1'b0;
        w_irw   = 1'b0;
        w_mr    = 1'b0;
        w_mw    = 1'b0;
        w_rw    = 1'b0;
        w_exc   = 1'b0;
        case (w_next)
            S_FETCH: begin
                w_mr   = 1'b1;
                w_ulab = SRC_FOUR;
                w_irw  = (w_cnt_next == CNT_LAST);
                w_pcw  = (w_cnt_next == CNT_LAST);
            end
            S_DECODE: w_ulab = SRC_EXTSH;
            S_EXEC_R: begin
                w_ulaa = 1'b1;
                case (w_fn)
                    FN_SUB:  w_ulaop = ALU_SUB;
                    FN_AND:  w_ulaop = ALU_AND;
                    FN_OR:   w_ulaop = ALU_OR;
                    FN_SLT:  w_ulaop = ALU_SLT;
                    default: w_ulaop = ALU_ADD;
                endcase
            end
            S_EXEC_I, S_ADDR: begin
                w_ulaa = 1'b1;
                w_ulab = SRC_EXT;
            end
            S_MEM_RD: w_mr = 1'b1;
            S_MEM_WR: w_mw = 1'b1;
            S_BRANCH: begin
                w_ulaa  = 1'b1;
                w_ulaop = ALU_SUB;
                w_pcw   = ((w_op == OP_BEQ) && zero) || ((w_op == OP_BNE) && !zero);
            end
            S_JUMP:   w_pcw = 1'b1;
            S_WB:     w_rw  = 1'b1;
            S_TRAP:   w_exc = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_FETCH;
            r_cnt    <= '0;
            r_opcode <= '0;
            r_funct  <= '0;
            ULAa     <= 1'b0;
            ULAb     <= SRC_B;
            ULAop    <= ALU_ADD;
            PCWrite  <= 1'b0;
            IRWrite  <= 1'b0;
            MemRead  <= 1'b0;
            MemWrite <= 1'b0;
            RegWrite <= 1'b0;
            exc      <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (r_state == S_DECODE) begin
                r_opcode <= opcode;
                r_funct  <= funct;
            end
            ULAa     <= w_ulaa;
            ULAb     <= w_ulab;
            ULAop    <= w_ulaop;
            PCWrite  <= w_pcw;
            IRWrite  <= w_irw;
            MemRead  <= w_mr;
            MemWrite <= w_mw;
            RegWrite <= w_rw;
            exc      <= w_exc;
        end
    end

endmodule

// File: tb/tb_ula_src_ctrl.sv
// Directed bench for ula_src_ctrl: hand-computed per-cycle output vectors for each
// instruction class, plus per-cycle checks on ULAb range and strobe exclusivity.
module tb_ula_src_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       overflow;
    logic       ULAa;
    logic [2:0] ULAb;
    logic [2:0] ULAop;
    logic       PCWrite;
    logic       IRWrite;
    logic       MemRead;
    logic       MemWrite;
    logic       RegWrite;
    logic       exc;
    logic [3:0] state;

    int n_total = 0;
    int n_bad   = 0;

    localparam logic [3:0] FE = 4'd0, DE = 4'd1, ER = 4'd2, EI = 4'd3, AD = 4'd4,
                           MR = 4'd5, MW = 4'd6, BR = 4'd7, JP = 4'd8, WB = 4'd9,
                           TR = 4'd10;

    ula_src_ctrl #(.MEM_WAIT(2), .CNT_W(3)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .overflow(overflow), .ULAa(ULAa), .ULAb(ULAb), .ULAop(ULAop),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .exc(exc), .state(state)
    );

    always #5 clk = ~clk;

    // {state, ULAa, ULAb, ULAop, PCWrite, IRWrite, MemRead, MemWrite, RegWrite, exc}
    function automatic logic [16:0] ex(input logic [3:0] st, input logic a,
                                       input logic [2:0] b, input logic [2:0] op,
                                       input logic pcw, input logic irw, input logic mr,
                                       input logic mw, input logic rw, input logic e);
        return {st, a, b, op, pcw, irw, mr, mw, rw, e};
    endfunction

    task automatic chk(input string tag, input logic [16:0] exp_v);
        logic [16:0] obs;
        obs = {state, ULAa, ULAb, ULAop, PCWrite, IRWrite, MemRead, MemWrite, RegWrite, exc};
        n_total++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Advance one clock and sample 1 time unit after the edge; invariants checked every cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        n_total++;
        assert ((ULAb <= 3'd4) && $onehot0({MemRead, MemWrite, RegWrite})) else begin
            n_bad++;
            $error("FAIL invariant observed ULAb=%b strobes=%b expected ULAb<=100 onehot0",
                   ULAb, {MemRead, MemWrite, RegWrite});
        end
    endtask

    task automatic fetch_pair(input string tag);
        tick(); chk({tag, "_f1"}, ex(FE, 0, 3'b010, 3'b000, 0, 0, 1, 0, 0, 0));
        tick(); chk({tag, "_f2"}, ex(FE, 0, 3'b010, 3'b000, 1, 1, 1, 0, 0, 0));
    endtask

    task automatic decode(input string tag);
        tick(); chk({tag, "_dec"}, ex(DE, 0, 3'b100, 3'b000, 0, 0, 0, 0, 0, 0));
    endtask

    logic [5:0] fn_tab [4] = '{6'h20, 6'h24, 6'h25, 6'h2A};
    logic [2:0] op_tab [4] = '{3'b000, 3'b010, 3'b011, 3'b100};

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; opcode = 6'h00; funct = 6'h22; zero = 1'b0; overflow = 1'b0;
        tick(); tick();
        chk("reset", ex(FE, 0, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0));
        reset = 1'b0;
        tick(); chk("pre_f2", ex(FE, 0, 3'b010, 3'b000, 1, 1, 1, 0, 0, 0));
        decode("pre");
        tick(); chk("pre_exr", ex(ER, 1, 3'b000, 3'b001, 0, 0, 0, 0, 0, 0));

        // Reset held 3 cycles mid-EXEC_R aborts the instruction.
        reset = 1'b1;
        tick(); chk("abort1", ex(FE, 0, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0));
        tick(); chk("abort2", ex(FE, 0, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0));
        tick(); chk("abort3", ex(FE, 0, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0));
        reset = 1'b0;
        chk("rel_f1", ex(FE, 0, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0));
        tick(); chk("rel_f2", ex(FE, 0, 3'b010, 3'b000, 1, 1, 1, 0, 0, 0));

        // sub; funct changed after DECODE must be ignored.
        opcode = 6'h00; funct = 6'h22; overflow = 1'b0;
        decode("sub");
        tick(); chk("sub_exr", ex(ER, 1, 3'b000, 3'b001, 0, 0, 0, 0, 0, 0));
        funct = 6'h3F;
        tick(); chk("sub_wb", ex(WB, 0, 3'b000, 3'b000, 0, 0, 0, 0, 1, 0));
        fetch_pair("sub");

        // lw; opcode switched to sw in ADDR must not redirect to MEM_WR.
        opcode = 6'h23;
        decode("lw");
        tick(); chk("lw_addr", ex(AD, 1, 3'b001, 3'b000, 0, 0, 0, 0, 0, 0));
        opcode = 6'h2B;
        tick(); chk("lw_mr1", ex(MR, 0, 3'b000, 3'b000, 0, 0, 1, 0, 0, 0));
        tick(); chk("lw_mr2", ex(MR, 0, 3'b000, 3'b000, 0, 0, 1, 0, 0, 0));
        tick(); chk("lw_wb", ex(WB, 0, 3'b000, 3'b000, 0, 0, 0, 0, 1, 0));
        fetch_pair("lw");

        opcode = 6'h2B;
        decode("sw");
        tick(); chk("sw_addr", ex(AD, 1, 3'b001, 3'b000, 0, 0, 0, 0, 0, 0));
        tick(); chk("sw_mw1", ex(MW, 0, 3'b000, 3'b000, 0, 0, 0, 1, 0, 0));
        tick(); chk("sw_mw2", ex(MW, 0, 3'b000, 3'b000, 0, 0, 0, 1, 0, 0));
        fetch_pair("sw");

        // Branches: beq/bne with both zero polarities.
        opcode = 6'h04; zero = 1'b1;
        decode("beq1");
        tick(); chk("beq1_br", ex(BR, 1, 3'b000, 3'b001, 1, 0, 0, 0, 0, 0));
        fetch_pair("beq1");
        zero = 1'b0;
        decode("beq0");
        tick(); chk("beq0_br", ex(BR, 1, 3'b000, 3'b001, 0, 0, 0, 0, 0, 0));
        fetch_pair("beq0");
        opcode = 6'h05;
        decode("bne0");
        tick(); chk("bne0_br", ex(BR, 1, 3'b000, 3'b001, 1, 0, 0, 0, 0, 0));
        fetch_pair("bne0");
        zero = 1'b1;
        decode("bne1");
        tick(); chk("bne1_br", ex(BR, 1, 3'b000, 3'b001, 0, 0, 0, 0, 0, 0));
        fetch_pair("bne1");
        zero = 1'b0;

        opcode = 6'h02;
        decode("j");
        tick(); chk("j_jump", ex(JP, 0, 3'b000, 3'b000, 1, 0, 0, 0, 0, 0));
        fetch_pair("j");

        // addi with and without overflow.
        opcode = 6'h08;
        decode("addiov");
        tick(); chk("addiov_exi", ex(EI, 1, 3'b001, 3'b000, 0, 0, 0, 0, 0, 0));
        overflow = 1'b1;
        tick(); chk("addiov_trap", ex(TR, 0, 3'b000, 3'b000, 0, 0, 0, 0, 0, 1));
        overflow = 1'b0;
        fetch_pair("addiov");
        decode("addi");
        tick(); chk("addi_exi", ex(EI, 1, 3'b001, 3'b000, 0, 0, 0, 0, 0, 0));
        tick(); chk("addi_wb", ex(WB, 0, 3'b000, 3'b000, 0, 0, 0, 0, 1, 0));
        fetch_pair("addi");

        // R-type add overflow traps; remaining functs complete normally.
        opcode = 6'h00; funct = 6'h20;
        decode("addov");
        tick(); chk("addov_exr", ex(ER, 1, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0));
        overflow = 1'b1;
        tick(); chk("addov_trap", ex(TR, 0, 3'b000, 3'b000, 0, 0, 0, 0, 0, 1));
        overflow = 1'b0;
        fetch_pair("addov");
        for (int i = 0; i < 4; i++) begin
            funct = fn_tab[i];
            decode($sformatf("fn%0d", i));
            tick(); chk($sformatf("fn%0d_exr", i), ex(ER, 1, 3'b000, op_tab[i], 0, 0, 0, 0, 0, 0));
            tick(); chk($sformatf("fn%0d_wb", i), ex(WB, 0, 3'b000, 3'b000, 0, 0, 0, 0, 1, 0));
            fetch_pair($sformatf("fn%0d", i));
        end

        // Unknown funct traps after EXEC_R.
        funct = 6'h3F;
        decode("badfn");
        tick(); chk("badfn_exr", ex(ER, 1, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0));
        tick(); chk("badfn_trap", ex(TR, 0, 3'b000, 3'b000, 0, 0, 0, 0, 0, 1));
        fetch_pair("badfn");

        // Illegal opcode traps straight from DECODE, then a normal add recovers.
        opcode = 6'h3F;
        decode("ill");
        tick(); chk("ill_trap", ex(TR, 0, 3'b000, 3'b000, 0, 0, 0, 0, 0, 1));
        fetch_pair("ill");
        opcode = 6'h00; funct = 6'h20;
        decode("rec");
        tick(); chk("rec_exr", ex(ER, 1, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0));
        tick(); chk("rec_wb", ex(WB, 0, 3'b000, 3'b000, 0, 0, 0, 0, 1, 0));
        fetch_pair("rec");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/ula_src_ctrl.md
Name: ula_src_ctrl

Overview:
- Multicycle control sequencer that drives the ALU operand-select and operation lines for the datapath.
- Generates the 3-bit ULAb select consumed by the ALU-B source mux:
  - 000 = B
  - 001 = ext16_32
  - 010 = reg4 (constant 4)
  - 011 = reg1 (constant 1)
  - 100 = ext16_32_left_shifted
- Also drives the ALU-A select, ALU op, PC/IR write enables and memory strobes, stepping one state per clock.

Parameters:
- MEM_WAIT, 2, clock cycles a memory access is held before the next state (1..7).
- CNT_W, 3, width of the memory-wait counter.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- opcode  input  6  IR[31:26], sampled in DECODE
- funct  input  6  IR[5:0], sampled in DECODE
- zero  input  1  ALU zero flag, sampled in BRANCH
- overflow  input  1  ALU overflow flag, sampled in EXEC_R / EXEC_I
- ULAa  output  1  ALU-A select: 0 = PC, 1 = A
- ULAb  output  3  ALU-B select, codes as in Overview
- ULAop  output  3  000 add, 001 sub, 010 and, 011 or, 100 slt
- PCWrite  output  1  PC load enable
- IRWrite  output  1  IR load enable
- MemRead  output  1  memory read strobe
- MemWrite  output  1  memory write strobe
- RegWrite  output  1  register-file write enable
- exc  output  1  exception pulse: overflow or illegal opcode
- state  output  4  current state encoding, debug only

Behaviour:
- Registered Moore outputs: all outputs are a function of the state register (and the wait counter) only.
- Reset:
  - On reset=1 at a clk edge: state := FETCH, wait counter := 0.
  - All enables and strobes := 0, ULAa = 0, ULAb = 000, ULAop = 000, exc = 0.
  - Reset asserted mid-instruction aborts the instruction with no further writes.
- States:
  - FETCH:
    - MemRead=1, ULAa=0, ULAb=010, ULAop=add.
    - Counter increments each cycle; stays in FETCH until counter == MEM_WAIT-1.
    - On that final cycle: IRWrite=1, PCWrite=1, counter := 0, then go to DECODE.
    - PC+4 and the IR load therefore happen exactly once, MEM_WAIT cycles after entry.
  - DECODE:
    - ULAa=0, ULAb=100, ULAop=add (branch target precompute).
    - Next state by opcode:
      - 0x00 → EXEC_R
      - 0x08 → EXEC_I
      - 0x23 / 0x2B → ADDR
      - 0x04 / 0x05 → BRANCH
      - 0x02 → JUMP
      - anything else → TRAP
  - EXEC_R:
    - ULAa=1, ULAb=000.
    - ULAop by funct: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt; unknown funct → TRAP.
    - Next WB, or TRAP if overflow=1 and funct is add or sub.
  - EXEC_I (addi):
    - ULAa=1, ULAb=001, ULAop=add.
    - Next WB, or TRAP on overflow.
  - ADDR:
    - ULAa=1, ULAb=001, ULAop=add.
    - lw → MEM_RD, sw → MEM_WR.
  - MEM_RD:
    - MemRead=1 for MEM_WAIT cycles, driven by the counter.
    - Then WB, counter := 0.
  - MEM_WR:
    - MemWrite=1 for MEM_WAIT cycles.
    - Then FETCH, counter := 0.
  - BRANCH:
    - ULAa=1, ULAb=000, ULAop=sub.
    - PCWrite=1 iff (opcode==0x04 && zero) || (opcode==0x05 && !zero).
    - Next FETCH.
  - JUMP:
    - PCWrite=1, ULAb=000.
    - Next FETCH.
  - WB:
    - RegWrite=1 for exactly one cycle.
    - Next FETCH.
  - TRAP:
    - exc=1 for one cycle; RegWrite=0 and MemWrite=0, so an overflowed result is never written.
    - Next FETCH.
- Codes: ULAb codes 101..111 are never driven.
- Opcode/funct capture: opcode and funct are latched in DECODE and used by all later states of that instruction; input changes afterwards are ignored.
- Counter: saturates-free, always cleared on exiting any wait state.
- Mutual exclusion: no two of MemRead, MemWrite, RegWrite are ever high in the same cycle.
- Latency, with MEM_WAIT=2:
  - R-type / addi: 5 cycles, FETCH×2 + DECODE + EXEC + WB.
  - lw: 7 cycles.
  - sw: 6 cycles.
  - beq / bne / j: 4 cycles.

Test Plan:
- Reset held 3 cycles mid-EXEC_R, then released → state=FETCH, all enables 0, ULAb=000; FETCH lasts 2 cycles with IRWrite=PCWrite=1 only on the 2nd.
- opcode=0x00, funct=0x22, overflow=0 → DECODE ULAb=100, EXEC_R ULAb=000 ULAop=001, WB RegWrite=1 one cycle; back in FETCH at cycle 6.
- opcode=0x23 (lw) → ADDR ULAb=001; MemRead high 2 cycles in MEM_RD; RegWrite=1 in cycle 7; MemWrite never high.
- opcode=0x04 with zero=1 → PCWrite=1 in BRANCH; repeat with zero=0 → PCWrite=0; opcode=0x05 with zero=0 → PCWrite=1.
- opcode=0x08, overflow=1 → exc=1 one cycle, RegWrite stays 0, next state FETCH.
- opcode=0x3F (illegal) → TRAP after DECODE, exc=1; then a normal add completes, confirming recovery; ULAb never in 101..111 across all runs.
